// File: rtl/uart_transceiver_cfg.sv
// Configurable full-duplex UART: 16x oversampled receiver and transmitter
// driven from one shared enable16 tick. Supports 5..8 data bits, optional
// even/odd parity, 1 or 2 TX stop bits, start-bit glitch rejection, and
// parity/frame error reporting. RX and TX run independently.
module uart_transceiver_cfg #(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_EN   = 0,
  parameter int PARITY_ODD  = 0,
  parameter int STOP_BITS   = 1,
  parameter int DIV_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 sys_clk,
  input  logic                 sys_rst,
  input  logic [DIV_W-1:0]     divisor,
  input  logic                 uart_rx,
  output logic                 uart_tx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_wr,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam logic       PAR_ON    = (PARITY_EN != 0);
  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  // Parity bit for a data word: even parity is the XOR of all bits,
  // odd parity is its inverse.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
    return (^d) ^ (PARITY_ODD != 0);
  endfunction

  // ---------------------------------------------------------------------
  // enable16 tick generator
  // ---------------------------------------------------------------------
  logic [DIV_W-1:0] baud_cnt_r;
  logic [DIV_W-1:0] reload_s;
  logic             tick_s;

  // Reload value; a zero divisor is treated as one so the tick never stalls.
  always_comb begin
    reload_s = {DIV_W{1'b0}};
    if (divisor == {DIV_W{1'b0}}) begin
      reload_s = {DIV_W{1'b0}};
    end else begin
      reload_s = divisor - DIV_W'(1);
    end
  end

  assign tick_s = (baud_cnt_r == {DIV_W{1'b0}});

  // Down-counter; a new divisor is picked up only when the counter reloads.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      baud_cnt_r <= reload_s;
    end else if (tick_s) begin
      baud_cnt_r <= reload_s;
    end else begin
      baud_cnt_r <= baud_cnt_r - DIV_W'(1);
    end
  end

  // ---------------------------------------------------------------------
  // RX line synchroniser
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_r;
  logic                   rx_line_s;

  // Metastability chain for the asynchronous serial input; resets to idle-high.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sync_r <= {SYNC_STAGES{1'b1}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], uart_rx};
    end
  end

  assign rx_line_s = sync_r[SYNC_STAGES-1];

  // ---------------------------------------------------------------------
  // Receiver
  // ---------------------------------------------------------------------
  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4,
    RX_BREAK  = 3'd5
  } rx_state_t;

  rx_state_t            rx_state_r;
  logic [3:0]           rx_tick_r;
  logic [2:0]           rx_bit_r;
  logic [DATA_BITS-1:0] rx_shift_r;
  logic                 rx_par_r;
  logic [DATA_BITS-1:0] rx_data_r;
  logic                 rx_done_r;
  logic                 rx_perr_r;
  logic                 rx_ferr_r;

  // RX frame FSM: mid-start validation after 8 ticks, then one sample every
  // 16 ticks; a low stop bit reports a frame error and waits out the break.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rx_state_r <= RX_IDLE;
      rx_tick_r  <= 4'd0;
      rx_bit_r   <= 3'd0;
      rx_shift_r <= {DATA_BITS{1'b0}};
      rx_par_r   <= 1'b0;
      rx_data_r  <= {DATA_BITS{1'b0}};
      rx_done_r  <= 1'b0;
      rx_perr_r  <= 1'b0;
      rx_ferr_r  <= 1'b0;
    end else begin
      rx_done_r <= 1'b0;
      rx_perr_r <= 1'b0;
      rx_ferr_r <= 1'b0;
      case (rx_state_r)
        RX_IDLE: begin
          if (tick_s && !rx_line_s) begin
            rx_state_r <= RX_START;
            rx_tick_r  <= 4'd0;
          end
        end
        RX_START: begin
          if (tick_s) begin
            if (rx_tick_r == 4'd7) begin
              rx_tick_r <= 4'd0;
              rx_bit_r  <= 3'd0;
              if (rx_line_s) begin
                rx_state_r <= RX_IDLE;
              end else begin
                rx_state_r <= RX_DATA;
              end
            end else begin
              rx_tick_r <= rx_tick_r + 4'd1;
            end
          end
        end
        RX_DATA: begin
          if (tick_s) begin
            rx_tick_r <= rx_tick_r + 4'd1;
            if (rx_tick_r == 4'd15) begin
              rx_shift_r <= {rx_line_s, rx_shift_r[DATA_BITS-1:1]};
              rx_bit_r   <= rx_bit_r + 3'd1;
              if (rx_bit_r == LAST_BIT) begin
                rx_state_r <= PAR_ON ? RX_PARITY : RX_STOP;
              end
            end
          end
        end
        RX_PARITY: begin
          if (tick_s) begin
            rx_tick_r <= rx_tick_r + 4'd1;
            if (rx_tick_r == 4'd15) begin
              rx_par_r   <= rx_line_s;
              rx_state_r <= RX_STOP;
            end
          end
        end
        RX_STOP: begin
          if (tick_s) begin
            rx_tick_r <= rx_tick_r + 4'd1;
            if (rx_tick_r == 4'd15) begin
              rx_done_r <= 1'b1;
              rx_data_r <= rx_shift_r;
              rx_perr_r <= PAR_ON && (rx_par_r != parity_bit(rx_shift_r));
              if (rx_line_s) begin
                rx_ferr_r  <= 1'b0;
                rx_state_r <= RX_IDLE;
              end else begin
                rx_ferr_r  <= 1'b1;
                rx_state_r <= RX_BREAK;
              end
            end
          end
        end
        RX_BREAK: begin
          if (rx_line_s) begin
            rx_state_r <= RX_IDLE;
          end
        end
        default: begin
          rx_state_r <= RX_IDLE;
        end
      endcase
    end
  end

  assign rx_data       = rx_data_r;
  assign rx_done       = rx_done_r;
  assign rx_parity_err = rx_perr_r;
  assign rx_frame_err  = rx_ferr_r;

  // ---------------------------------------------------------------------
  // Transmitter
  // ---------------------------------------------------------------------
  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_t;

  tx_state_t            tx_state_r;
  logic [3:0]           tx_tick_r;
  logic [2:0]           tx_bit_r;
  logic [DATA_BITS-1:0] tx_shift_r;
  logic                 tx_par_r;
  logic                 uart_tx_r;
  logic                 tx_busy_r;
  logic                 tx_done_r;

  // TX frame FSM: each bit is held for 16 ticks; requests while busy are dropped.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      tx_state_r <= TX_IDLE;
      tx_tick_r  <= 4'd0;
      tx_bit_r   <= 3'd0;
      tx_shift_r <= {DATA_BITS{1'b0}};
      tx_par_r   <= 1'b0;
      uart_tx_r  <= 1'b1;
      tx_busy_r  <= 1'b0;
      tx_done_r  <= 1'b0;
    end else begin
      tx_done_r <= 1'b0;
      case (tx_state_r)
        TX_IDLE: begin
          if (tx_wr && !tx_busy_r) begin
            tx_state_r <= TX_START;
            tx_shift_r <= tx_data;
            tx_par_r   <= parity_bit(tx_data);
            tx_tick_r  <= 4'd0;
            uart_tx_r  <= 1'b0;
            tx_busy_r  <= 1'b1;
          end
        end
        TX_START: begin
          if (tick_s) begin
            tx_tick_r <= tx_tick_r + 4'd1;
            if (tx_tick_r == 4'd15) begin
              uart_tx_r  <= tx_shift_r[0];
              tx_shift_r <= {1'b0, tx_shift_r[DATA_BITS-1:1]};
              tx_bit_r   <= 3'd0;
              tx_state_r <= TX_DATA;
            end
          end
        end
        TX_DATA: begin
          if (tick_s) begin
            tx_tick_r <= tx_tick_r + 4'd1;
            if (tx_tick_r == 4'd15) begin
              if (tx_bit_r == LAST_BIT) begin
                tx_bit_r <= 3'd0;
                if (PAR_ON) begin
                  uart_tx_r  <= tx_par_r;
                  tx_state_r <= TX_PARITY;
                end else begin
                  uart_tx_r  <= 1'b1;
                  tx_state_r <= TX_STOP;
                end
              end else begin
                uart_tx_r  <= tx_shift_r[0];
                tx_shift_r <= {1'b0, tx_shift_r[DATA_BITS-1:1]};
                tx_bit_r   <= tx_bit_r + 3'd1;
              end
            end
          end
        end
        TX_PARITY: begin
          if (tick_s) begin
            tx_tick_r <= tx_tick_r + 4'd1;
            if (tx_tick_r == 4'd15) begin
              uart_tx_r  <= 1'b1;
              tx_bit_r   <= 3'd0;
              tx_state_r <= TX_STOP;
            end
          end
        end
        TX_STOP: begin
          if (tick_s) begin
            tx_tick_r <= tx_tick_r + 4'd1;
            if (tx_tick_r == 4'd15) begin
              if (tx_bit_r == LAST_STOP) begin
                tx_done_r  <= 1'b1;
                tx_busy_r  <= 1'b0;
                tx_state_r <= TX_IDLE;
              end else begin
                tx_bit_r <= tx_bit_r + 3'd1;
              end
            end
          end
        end
        default: begin
          tx_state_r <= TX_IDLE;
          uart_tx_r  <= 1'b1;
          tx_busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign uart_tx = uart_tx_r;
  assign tx_busy = tx_busy_r;
  assign tx_done = tx_done_r;

endmodule

// File: tb/tb_uart_transceiver_cfg.sv
// Self-checking bench: instance A is 8N1 (TX tests, loopback, break, glitch),
// instance B is 8E1 (parity error detection). Received words are checked
// against a scoreboard queue filled when the stimulus is driven.
module tb_uart_transceiver_cfg;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [15:0] divisor;

  // clock generator
  always #5 sys_clk = ~sys_clk;

  logic       rx_drv_a, rx_drv_b, loop_en;
  logic       uart_rx_a;
  logic       uart_tx_a, uart_tx_b;
  logic [7:0] rx_data_a, rx_data_b;
  logic       rx_done_a, rx_done_b;
  logic       rx_perr_a, rx_perr_b;
  logic       rx_ferr_a, rx_ferr_b;
  logic [7:0] tx_data_a, tx_data_b;
  logic       tx_wr_a, tx_wr_b;
  logic       tx_busy_a, tx_busy_b;
  logic       tx_done_a, tx_done_b;

  assign uart_rx_a = loop_en ? uart_tx_a : rx_drv_a;

  uart_transceiver_cfg #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1),
                         .DIV_W(16), .SYNC_STAGES(2)) dut_a (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .divisor(divisor), .uart_rx(uart_rx_a),
    .uart_tx(uart_tx_a), .rx_data(rx_data_a), .rx_done(rx_done_a),
    .rx_parity_err(rx_perr_a), .rx_frame_err(rx_ferr_a), .tx_data(tx_data_a),
    .tx_wr(tx_wr_a), .tx_busy(tx_busy_a), .tx_done(tx_done_a));

  uart_transceiver_cfg #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1),
                         .DIV_W(16), .SYNC_STAGES(2)) dut_b (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .divisor(divisor), .uart_rx(rx_drv_b),
    .uart_tx(uart_tx_b), .rx_data(rx_data_b), .rx_done(rx_done_b),
    .rx_parity_err(rx_perr_b), .rx_frame_err(rx_ferr_b), .tx_data(tx_data_b),
    .tx_wr(tx_wr_b), .tx_busy(tx_busy_b), .tx_done(tx_done_b));

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int   vec_cnt = 0;
  int   err_cnt = 0;
  int   rxa_cnt = 0;
  int   rxb_cnt = 0;
  int   txa_done_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // scoreboard for instance A received frames
  always @(negedge sys_clk) begin
    if (rx_done_a) begin
      rxa_cnt++;
      chk("rxa_q_nonempty", 32'(qa.size() > 0), 32'd1);
      if (qa.size() > 0) begin
        ea = qa.pop_front();
        chk("rxa_data", 32'(rx_data_a), 32'(ea.d));
        chk("rxa_perr", 32'(rx_perr_a), 32'(ea.pe));
        chk("rxa_ferr", 32'(rx_ferr_a), 32'(ea.fe));
      end
    end
    if (tx_done_a) txa_done_cnt++;
  end

  // scoreboard for instance B received frames
  always @(negedge sys_clk) begin
    if (rx_done_b) begin
      rxb_cnt++;
      chk("rxb_q_nonempty", 32'(qb.size() > 0), 32'd1);
      if (qb.size() > 0) begin
        eb = qb.pop_front();
        chk("rxb_data", 32'(rx_data_b), 32'(eb.d));
        chk("rxb_perr", 32'(rx_perr_b), 32'(eb.pe));
        chk("rxb_ferr", 32'(rx_ferr_b), 32'(eb.fe));
      end
    end
  end

  task automatic do_reset(input logic [15:0] d);
    divisor = d;
    sys_rst = 1'b1;
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);
  endtask

  task automatic pulse_wr(input logic [7:0] d);
    tx_data_a = d;
    tx_wr_a   = 1'b1;
    @(negedge sys_clk);
    tx_wr_a   = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] d);
    for (int i = 0; i < 5000 && tx_busy_a; i++) @(negedge sys_clk);
    chk("tx_ready", 32'(tx_busy_a), 32'd0);
    qa.push_back('{d: d, pe: 1'b0, fe: 1'b0});
    pulse_wr(d);
  endtask

  task automatic set_line(input int which, input logic v, input int bt);
    if (which == 0) rx_drv_a = v;
    else            rx_drv_b = v;
    repeat (bt) @(negedge sys_clk);
  endtask

  task automatic drive_frame(input int which, input logic [7:0] d, input logic par_en,
                             input logic par_val, input logic stop_val);
    int bt;
    bt = 16 * int'(divisor);
    set_line(which, 1'b0, bt);
    for (int i = 0; i < 8; i++) set_line(which, d[i], bt);
    if (par_en) set_line(which, par_val, bt);
    set_line(which, stop_val, bt);
  endtask

  task automatic wait_qa_empty(input string tag);
    for (int i = 0; i < 4000 && qa.size() > 0; i++) @(negedge sys_clk);
    chk(tag, 32'(qa.size()), 32'd0);
  endtask

  // bound on total run time
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   s, r1, f2, lows;
    logic prev;

    sys_rst = 1'b1; divisor = 16'd4; loop_en = 1'b0;
    rx_drv_a = 1'b1; rx_drv_b = 1'b1;
    tx_wr_a = 1'b0; tx_data_a = 8'h00; tx_wr_b = 1'b0; tx_data_b = 8'h00;
    repeat (3) @(negedge sys_clk);

    // reset state
    chk("rst_uart_tx", 32'(uart_tx_a), 32'd1);
    chk("rst_rx_data", 32'(rx_data_a), 32'd0);
    chk("rst_rx_done", 32'(rx_done_a), 32'd0);
    chk("rst_tx_busy", 32'(tx_busy_a), 32'd0);
    chk("rst_tx_done", 32'(tx_done_a), 32'd0);
    chk("rst_flags",   32'({rx_perr_a, rx_ferr_a}), 32'd0);
    sys_rst = 1'b0;
    @(negedge sys_clk);

    // T1: divisor 4, 8N1, transmit 0x55
    s = txa_done_cnt; r1 = -1; f2 = -1;
    pulse_wr(8'h55);
    chk("t1_start_low", 32'(uart_tx_a), 32'd0);
    chk("t1_busy", 32'(tx_busy_a), 32'd1);
    prev = uart_tx_a;
    for (int c = 0; c < 700; c++) begin
      if (c > 0) begin
        if (uart_tx_a && !prev && r1 < 0) r1 = c;
        if (!uart_tx_a && prev && r1 >= 0 && f2 < 0) f2 = c;
        prev = uart_tx_a;
      end
      if ((c % 64) == 32 && c < 640) chk($sformatf("t1_bit%0d", c / 64), 32'(uart_tx_a), 32'((c / 64) % 2));
      @(negedge sys_clk);
    end
    chk("t1_bit_len", 32'(f2 - r1), 32'd64);
    chk("t1_done_cnt", 32'(txa_done_cnt - s), 32'd1);
    chk("t1_busy_end", 32'(tx_busy_a), 32'd0);
    chk("t1_idle_high", 32'(uart_tx_a), 32'd1);

    // T2: loopback at divisor 2, three back-to-back words
    do_reset(16'd2);
    loop_en = 1'b1;
    s = rxa_cnt;
    send_word(8'h00);
    send_word(8'hA5);
    send_word(8'hFF);
    wait_qa_empty("t2_q_empty");
    repeat (64) @(negedge sys_clk);
    chk("t2_rx_count", 32'(rxa_cnt - s), 32'd3);
    loop_en = 1'b0;
    repeat (64) @(negedge sys_clk);

    // T3: even parity instance, wrong then correct parity bit
    s = rxb_cnt;
    qb.push_back('{d: 8'h03, pe: 1'b1, fe: 1'b0});
    drive_frame(1, 8'h03, 1'b1, 1'b1, 1'b1);
    qb.push_back('{d: 8'h07, pe: 1'b0, fe: 1'b0});
    drive_frame(1, 8'h07, 1'b1, 1'b1, 1'b1);
    repeat (64) @(negedge sys_clk);
    chk("t3_qb_empty", 32'(qb.size()), 32'd0);
    chk("t3_rx_count", 32'(rxb_cnt - s), 32'd2);

    // T4: stop bit low followed by a 40-bit-time break
    s = rxa_cnt;
    qa.push_back('{d: 8'h81, pe: 1'b0, fe: 1'b1});
    drive_frame(0, 8'h81, 1'b0, 1'b0, 1'b0);
    repeat (40 * 32) @(negedge sys_clk);
    chk("t4_one_done", 32'(rxa_cnt - s), 32'd1);
    rx_drv_a = 1'b1;
    repeat (3 * 32) @(negedge sys_clk);
    chk("t4_after_break", 32'(rxa_cnt - s), 32'd1);
    chk("t4_q_empty", 32'(qa.size()), 32'd0);

    // T5: 5-tick glitch is rejected, following frame 0x3C received
    s = rxa_cnt;
    rx_drv_a = 1'b0;
    repeat (10) @(negedge sys_clk);
    rx_drv_a = 1'b1;
    repeat (4 * 32) @(negedge sys_clk);
    chk("t5_glitch", 32'(rxa_cnt - s), 32'd0);
    qa.push_back('{d: 8'h3C, pe: 1'b0, fe: 1'b0});
    drive_frame(0, 8'h3C, 1'b0, 1'b0, 1'b1);
    repeat (64) @(negedge sys_clk);
    chk("t5_rx_count", 32'(rxa_cnt - s), 32'd1);
    chk("t5_q_empty", 32'(qa.size()), 32'd0);

    // T6: write while busy is ignored, sync reset aborts the frame
    s = txa_done_cnt;
    pulse_wr(8'h11);
    repeat (5) @(negedge sys_clk);
    pulse_wr(8'h22);
    chk("t6_busy", 32'(tx_busy_a), 32'd1);
    repeat (42) @(negedge sys_clk);
    chk("t6_bit0", 32'(uart_tx_a), 32'd1);
    repeat (32) @(negedge sys_clk);
    chk("t6_bit1", 32'(uart_tx_a), 32'd0);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    chk("t6_rst_tx", 32'(uart_tx_a), 32'd1);
    chk("t6_rst_busy", 32'(tx_busy_a), 32'd0);
    sys_rst = 1'b0;
    lows = 0;
    for (int c = 0; c < 640; c++) begin
      @(negedge sys_clk);
      if (!uart_tx_a) lows++;
    end
    chk("t6_no_tx", 32'(lows), 32'd0);
    chk("t6_no_done", 32'(txa_done_cnt - s), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
